// File: rtl/reg_tx_pkg.sv
// Shared types and field layout for the register-image UART transmitter.
package reg_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_SKIP,
    ST_DONE
  } state_e;

  localparam int BANK_BIT    = 7;
  localparam int ADDR_MSB    = 6;
  localparam int ADDR_LSB    = 4;
  localparam int DATA_MSB    = 3;
  localparam int NUM_NIBBLES = 16;

  // Wire byte: bank in bit7, address in bits6:4, data nibble in bits3:0.
  function automatic logic [7:0] pack_byte(input logic [3:0] idx, input logic [3:0] nib);
    logic [7:0] b;
    b                    = '0;
    b[BANK_BIT]          = idx[3];
    b[ADDR_MSB:ADDR_LSB] = idx[2:0];
    b[DATA_MSB:0]        = nib;
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: baud counter plus LSB-first shift register.
// byte_ready_o is also high in the last stop-bit cycle so a new byte can
// follow with no idle gap.
module uart_tx_byte
  import reg_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 1250
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       byte_ready_o,
  output logic       byte_done_o,
  output logic       tx_o
);

  localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);

  state_e      phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        tick;

  assign tick         = (cnt_q == '0);
  assign byte_done_o  = (phase_q == ST_STOP) && tick;
  assign byte_ready_o = (phase_q == ST_IDLE) || byte_done_o;
  assign tx_o         = tx_q;

  // Next-state: count each bit down, advance start -> data -> stop, load on handshake.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    if (phase_q != ST_IDLE) cnt_d = tick ? RELOAD : cnt_q - 16'd1;
    case (phase_q)
      ST_START: if (tick) begin
        phase_d = ST_DATA;
        tx_d    = sh_q[0];
        bit_d   = '0;
      end
      ST_DATA: if (tick) begin
        if (bit_q == 3'd7) begin
          phase_d = ST_STOP;
          tx_d    = 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
          sh_d  = {1'b0, sh_q[7:1]};
          tx_d  = sh_q[1];
        end
      end
      ST_STOP: if (tick) begin
        phase_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: ;
    endcase
    if (byte_valid_i && byte_ready_o) begin
      phase_d = ST_START;
      cnt_d   = RELOAD;
      sh_d    = byte_i;
      bit_d   = '0;
      tx_d    = 1'b0;
    end
  end

  // Serializer state; line idles high and snaps high on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/register_uart_tx.sv
// Register-image UART transmitter: snapshots 16 nibbles and streams them as
// {bank, addr, nibble} bytes back-to-back over 8N1.
// Optional REG_TX_DELTA_EN: only nibbles that changed since last sent go out;
// each skipped nibble costs one cycle in ST_SKIP.
// At this level ST_START means "a frame is in flight"; the bit-level
// START/DATA/STOP sequencing lives in uart_tx_byte.
module register_uart_tx
  import reg_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 1250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] reg_data,
  input  logic        dump_req,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [63:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;

  logic        eng_ready, eng_done, load, accept, cand_need;
  logic [3:0]  nxt_idx, cand_idx, cand_val;

  // A new dump starts from IDLE on request, or straight out of DONE when one is queued.
  assign accept   = eng_ready &&
                    (((state_q == ST_IDLE) && dump_req) ||
                     ((state_q == ST_DONE) && (pending_q || dump_req)));
  assign nxt_idx  = idx_q + 4'd1;
  // Candidate nibble for the next load: nibble 0 of live data on accept, else next shadow nibble.
  assign cand_idx = accept ? 4'd0 : nxt_idx;
  assign cand_val = accept ? reg_data[3:0] : shadow_q[4*nxt_idx +: 4];

`ifdef REG_TX_DELTA_EN
  logic [63:0] last_q, last_d;
  logic [15:0] mask_q, mask_d;

  assign cand_need = !mask_q[cand_idx] || (last_q[4*cand_idx +: 4] != cand_val);

  // Record every nibble as it is handed to the serializer.
  always_comb begin
    last_d = last_q;
    mask_d = mask_q;
    if (load) begin
      last_d[4*cand_idx +: 4] = cand_val;
      mask_d[cand_idx]        = 1'b1;
    end
  end

  // Last-sent image and valid mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      mask_q <= '0;
    end else begin
      last_q <= last_d;
      mask_q <= mask_d;
    end
  end
`else
  assign cand_need = 1'b1;
`endif

  // Dump sequencer: accept, walk nibbles 0..15 sending or skipping, pulse done.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    load     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          shadow_d = reg_data;
          idx_d    = '0;
          load     = cand_need;
          state_d  = cand_need ? ST_START : ST_SKIP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START, ST_SKIP: begin
        if ((state_q == ST_SKIP) || eng_done) begin
          if (idx_q == 4'(NUM_NIBBLES - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = nxt_idx;
            load    = cand_need;
            state_d = cand_need ? ST_START : ST_SKIP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One queued request at most; any request seen while not idle lands here.
  always_comb begin
    pending_d = pending_q;
    if (accept)                             pending_d = 1'b0;
    else if (dump_req && state_q != ST_IDLE) pending_d = 1'b1;
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_byte (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .byte_valid_i (load),
    .byte_i       (pack_byte(cand_idx, cand_val)),
    .byte_ready_o (eng_ready),
    .byte_done_o  (eng_done),
    .tx_o         (tx)
  );

  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_register_uart_tx.sv
// Directed bench for register_uart_tx: three instances (BAUD_DIV 4, 2, 1250)
// and a cycle-sampling UART receiver that also checks every bit holds for
// exactly BAUD_DIV cycles.
module tb_register_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic        rst_n, dump_req, tx, busy, done;
  logic [63:0] reg_data;
  logic        rst2_n, dr2, tx2, busy2, done2;
  logic [63:0] rd2;
  logic        rstL_n, drL, txL, busyL, doneL;
  logic [63:0] rdL;

  logic [7:0] rxb [16];
  int         done_cyc;
  int         t0;

  register_uart_tx #(.BAUD_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .reg_data(reg_data), .dump_req(dump_req),
    .tx(tx), .busy(busy), .done(done));
  register_uart_tx #(.BAUD_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .reg_data(rd2), .dump_req(dr2),
    .tx(tx2), .busy(busy2), .done(done2));
  register_uart_tx #(.BAUD_DIV(1250)) dutL (
    .clk(clk), .rst_n(rstL_n), .reg_data(rdL), .dump_req(drL),
    .tx(txL), .busy(busyL), .done(doneL));

  function automatic logic cur_tx(input int sel);
    return (sel == 0) ? tx : (sel == 1) ? tx2 : txL;
  endfunction
  function automatic logic cur_busy(input int sel);
    return (sel == 0) ? busy : (sel == 1) ? busy2 : busyL;
  endfunction
  function automatic logic cur_done(input int sel);
    return (sel == 0) ? done : (sel == 1) ? done2 : doneL;
  endfunction

  // Pulse dump_req for one posedge; t0 = cycle count just after the accept edge.
  task automatic start_dump(input int sel, input string tag);
    @(negedge clk);
    case (sel)
      0: dump_req = 1'b1;
      1: dr2 = 1'b1;
      default: drL = 1'b1;
    endcase
    @(posedge clk);
    #1;
    dump_req = 1'b0; dr2 = 1'b0; drL = 1'b0;
    t0 = cyc;
    checks++;
    if (cur_busy(sel) !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_accept: got %b want 1", tag, cur_busy(sel));
    end
  endtask

  // Receive one frame; gap = idle cycles before the start bit.
  task automatic rx_frame(input int sel, input int bd, output logic [7:0] b,
                          output int gap, output bit stable);
    logic [9:0] bits;
    logic v;
    gap = 0; stable = 1'b1; bits = '1;
    @(negedge clk);
    while (cur_tx(sel) !== 1'b0 && gap < 20 * bd + 20) begin
      gap++;
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < bd; c++) begin
        if (!(k == 0 && c == 0)) @(negedge clk);
        v = cur_tx(sel);
        if (c == 0) bits[k] = v;
        else if (v !== bits[k]) stable = 1'b0;
      end
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) stable = 1'b0;
    b = bits[8:1];
  endtask

  // Receive a full 16-byte dump back-to-back, then expect the done cycle.
  task automatic rx_dump(input int sel, input int bd, input logic [63:0] snap, input string tag);
    logic [7:0] b, exp;
    logic [3:0] ii;
    int gap;
    bit st;
    for (int i = 0; i < 16; i++) begin
      rx_frame(sel, bd, b, gap, st);
      rxb[i] = b;
      ii = i[3:0];
      exp = {ii, snap[4*i +: 4]};
      checks++;
      if (b !== exp || gap != 0 || !st) begin
        failures++;
        $display("FAIL %s byte%0d: got %h gap=%0d stable=%0d want %h gap=0 stable=1",
                 tag, i, b, gap, st, exp);
      end
    end
    @(negedge clk);
    done_cyc = cyc;
    checks++;
    if (cur_done(sel) !== 1'b1 || cur_busy(sel) !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse: got done=%b busy=%b want done=1 busy=0",
               tag, cur_done(sel), cur_busy(sel));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0; rstL_n = 1'b0;
    dump_req = 1'b0; dr2 = 1'b0; drL = 1'b0;
    reg_data = '0; rd2 = '0; rdL = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (cur_tx(s) !== 1'b1 || cur_busy(s) !== 1'b0 || cur_done(s) !== 1'b0) begin
        failures++;
        $display("FAIL reset_state dut%0d: got tx=%b busy=%b done=%b want 1 0 0",
                 s, cur_tx(s), cur_busy(s), cur_done(s));
      end
    end
    rst_n = 1'b1; rst2_n = 1'b1; rstL_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
    end
  endtask

  task automatic test_full_dump();
    reg_data = 64'hFEDCBA9876543210;
    start_dump(0, "full");
    rx_dump(0, 4, 64'hFEDCBA9876543210, "full");
    checks++;
    if (rxb[0] !== 8'h00 || rxb[7] !== 8'h77 || rxb[8] !== 8'h88 || rxb[15] !== 8'hFF) begin
      failures++;
      $display("FAIL full_bytes: got %h %h %h %h want 00 77 88 ff", rxb[0], rxb[7], rxb[8], rxb[15]);
    end
    checks++;
    if (done_cyc - t0 != 640) begin
      failures++;
      $display("FAIL full_length: got %0d cycles want 640", done_cyc - t0);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL full_idle: got done=%b busy=%b tx=%b want 0 0 1", done, busy, tx);
    end
  endtask

  task automatic test_snapshot();
    reg_data = 64'hFEDCBA9876543210;
    start_dump(0, "snap");
    fork
      rx_dump(0, 4, 64'hFEDCBA9876543210, "snap");
      begin repeat (10) @(negedge clk); reg_data = '0; end
    join
    checks++;
    if (rxb[5] !== 8'h55) begin
      failures++;
      $display("FAIL snap_byte5: got %h want 55", rxb[5]);
    end
  endtask

  task automatic test_pending();
    bit bad;
    reg_data = 64'h0123456789ABCDEF;
    start_dump(0, "pend1");
    fork
      rx_dump(0, 4, 64'h0123456789ABCDEF, "pend1");
      begin
        repeat (50) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
          dump_req = 1'b1;
          @(negedge clk);
          dump_req = 1'b0;
          repeat (30) @(negedge clk);
        end
        reg_data = 64'h5A3C96E1B4D2780F;
      end
    join
    rx_dump(0, 4, 64'h5A3C96E1B4D2780F, "pend2");
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL pend_single_extra: got extra activity want idle");
    end
  endtask

  task automatic test_done_edge();
    int n;
    reg_data = 64'hFEDCBA9876543210;
    start_dump(0, "edge1");
    rx_dump(0, 4, 64'hFEDCBA9876543210, "edge1");
    dump_req = 1'b1;
    @(posedge clk);
    #1;
    dump_req = 1'b0;
    t0 = cyc;
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL edge_restart: got tx=%b busy=%b want 0 1", tx, busy);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (done !== 1'b1 && n < 800);
    checks++;
    if (done !== 1'b1 || cyc - t0 != 640) begin
      failures++;
      $display("FAIL edge_second_done: got done=%b after %0d want 1 after 640", done, cyc - t0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int gap;
    bit st;
    reg_data = 64'hFEDCBA9876543210;
    start_dump(0, "mid");
    for (int i = 0; i < 7; i++) begin
      rx_frame(0, 4, b, gap, st);
      checks++;
      if (b !== 8'(17 * i) || gap != 0 || !st) begin
        failures++;
        $display("FAIL mid_byte%0d: got %h gap=%0d want %h gap=0", i, b, gap, 8'(17 * i));
      end
    end
    repeat (17) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL mid_bit3_of_0x77: got %b want 0", tx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_async_reset: got tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_dump(0, "after_rst");
    rx_dump(0, 4, 64'hFEDCBA9876543210, "after_rst");
    checks++;
    if (rxb[0] !== 8'h00) begin
      failures++;
      $display("FAIL after_rst_byte0: got %h want 00", rxb[0]);
    end
  endtask

  task automatic test_bit_timing();
    logic [7:0] b;
    int gap;
    bit st;
    rd2 = 64'h0123456789ABCDEF;
    start_dump(1, "bd2");
    rx_dump(1, 2, 64'h0123456789ABCDEF, "bd2");
    checks++;
    if (rxb[0] !== 8'h0F || rxb[9] !== 8'h96) begin
      failures++;
      $display("FAIL bd2_bytes: got %h %h want 0f 96", rxb[0], rxb[9]);
    end
    rdL = 64'h00000000000000A5;
    start_dump(2, "bd1250");
    rx_frame(2, 1250, b, gap, st);
    checks++;
    if (b !== 8'h05 || gap != 0 || !st) begin
      failures++;
      $display("FAIL bd1250_byte0: got %h gap=%0d stable=%0d want 05 gap=0 stable=1", b, gap, st);
    end
    rstL_n = 1'b0;
    #1;
    checks++;
    if (txL !== 1'b1 || busyL !== 1'b0) begin
      failures++;
      $display("FAIL bd1250_reset: got tx=%b busy=%b want 1 0", txL, busyL);
    end
  endtask

`ifdef REG_TX_DELTA_EN
  task automatic test_delta();
    logic [7:0] b;
    int gap, n;
    bit st, bad;
    reg_data = 64'hFEDCBA9876543210;
    start_dump(0, "delta1");
    rx_dump(0, 4, 64'hFEDCBA9876543210, "delta1");
    reg_data[39:36] = 4'h3;
    start_dump(0, "delta2");
    rx_frame(0, 4, b, gap, st);
    checks++;
    if (b !== 8'h93 || gap != 9 || !st) begin
      failures++;
      $display("FAIL delta2_byte: got %h gap=%0d want 93 gap=9", b, gap);
    end
    n = 0; bad = 1'b0;
    do begin
      @(negedge clk); n++;
      if (tx !== 1'b1) bad = 1'b1;
    end while (done !== 1'b1 && n < 100);
    checks++;
    if (n != 7 || bad) begin
      failures++;
      $display("FAIL delta2_done: got done after %0d txbusy=%b want 7 0", n, bad);
    end
    start_dump(0, "delta3");
    n = 0; bad = 1'b0;
    do begin
      @(negedge clk); n++;
      if (tx !== 1'b1) bad = 1'b1;
    end while (done !== 1'b1 && n < 100);
    checks++;
    if (cyc - t0 + 1 != 17 || done !== 1'b1 || bad) begin
      failures++;
      $display("FAIL delta3_nochange: got done=%b at %0d tx_activity=%b want 1 at 17 no activity",
               done, cyc - t0 + 1, bad);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef REG_TX_DELTA_EN
    test_delta();
`else
    test_full_dump();
    test_snapshot();
    test_pending();
    test_done_edge();
    test_reset_mid();
`endif
    test_bit_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
